// File: rtl/dram_rd_responder.sv
// dram_rd_responder: burst read slave over a preloadable word memory with fixed access latency
module dram_rd_responder #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int DEPTH  = 65536,
    parameter int BURST  = 32,
    parameter int RD_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            araddr,
    input  logic [3:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DW-1:0]            rdata,
    output logic                     rvalid,
    output logic                     rlast,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    output logic                     busy
);
    localparam int IW = $clog2(DEPTH);
    localparam int BS = $clog2(DW / 8);
    localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [LW-1:0] lat_cnt;
    logic [IW-1:0] rd_addr;
    logic [8:0] beats_left;
    logic accept, emit;
    assign arready = rst_n && state == S_IDLE;
    assign busy = state != S_IDLE;
    assign accept = arvalid && arready;
    // state register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;
    end
    // next state, plus the per-cycle "produce a beat" decision
    always_comb begin
        state_nxt = state;
        emit = (state == S_WAIT && lat_cnt == '0) || (state == S_BURST && !rlast);
        if (state == S_IDLE && accept) state_nxt = S_WAIT;
        if (state == S_WAIT && lat_cnt == '0) state_nxt = S_BURST;
        if (state == S_BURST && rlast) state_nxt = S_IDLE;
    end
    // request capture, latency countdown and registered beat outputs (memory read is read-first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            rd_addr <= '0;
            beats_left <= '0;
            rdata <= '0;
            rvalid <= 1'b0;
            rlast <= 1'b0;
        end else begin
            if (accept) begin
                rd_addr <= IW'(araddr >> BS);
                beats_left <= arburst == 4'd0 ? 9'(BURST) : 9'(arburst);
                lat_cnt <= LW'(RD_LAT - 1);
            end else if (state == S_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (emit) begin
                rdata <= mem[rd_addr];
                rd_addr <= rd_addr + 1'b1;
                beats_left <= beats_left - 1'b1;
                rvalid <= 1'b1;
                rlast <= beats_left == 9'd1;
            end else begin
                rvalid <= 1'b0;
                rlast <= 1'b0;
            end
        end
    end
    // preload port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule
